instr_fetch_queue: RTL and testbench

Producer end of the instruction/branch interface of the single-cycle core's decode and control path. The block owns the fetch PC and issues word requests to a synchronous instruction memory. It buffers returned words with their PCs in a small FIFO and presents them to the control unit through a valid/ready handshake. It consumes the control unit's pc_src / jump redirect, flushing all wrong-path state.

---
 rtl/instr_fetch_queue.sv | 151 +++++++++++++++
 tb/tb_instr_fetch_queue.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
//
// Fetch front end feeding the decode/control path. Owns the fetch PC, issues
// one word read per cycle to a synchronous instruction memory (data returns one
// cycle after the request), buffers returned words together with their PCs in
// a small FIFO and hands the head entry to the control unit.
//
// Handshake: the head entry is transferred on a rising edge where
// instr_valid=1 and instr_ready=1. instr_valid does not depend on
// instr_ready, and instr_ready is ignored while instr_valid=0.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-low reset
//   imem_req     read request issued this cycle
//   imem_addr    word address of the request (bits [1:0] always 0)
//   imem_rdata   instruction word, valid one cycle after imem_req
//   instr        head instruction, NOP (0x13) when instr_valid=0
//   instr_pc     PC of the head instruction, 0 when instr_valid=0
//   instr_valid  head entry present
//   instr_ready  consumer accepts the head entry this cycle
//   pc_src       redirect request (taken branch / jump)
//   pc_target    redirect address, bits [1:0] ignored
// -----------------------------------------------------------------------------
module instr_fetch_queue #(
  parameter int              WIDTH    = 32,
  parameter int              DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             pc_src,
  input  logic [WIDTH-1:0] pc_target
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] NOP = WIDTH'(32'h0000_0013);

  // Fetch state
  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] req_pc;      // PC of the request whose data arrives now
  logic             inflight;    // a response is on imem_rdata this cycle

  // Queue state
  logic [WIDTH-1:0] q_instr [DEPTH];
  logic [WIDTH-1:0] q_pc    [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [AW:0]      count;

  // Combinational control
  logic [AW+1:0]    occupancy;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] target_aligned;
  logic             unused_target_bits;

  assign target_aligned     = {pc_target[WIDTH-1:2], 2'b00};
  assign unused_target_bits = ^pc_target[1:0];

  // Slots already spoken for: stored entries plus the response on its way.
  // Reserving a slot at request time is what makes overflow impossible.
  assign occupancy = {1'b0, count} + {{(AW+1){1'b0}}, inflight};

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = fetch_pc;
    if (rst && !pc_src && (occupancy < (AW+2)'(DEPTH))) begin
      imem_req = 1'b1;
    end
  end

  // No request is ever issued in a redirect cycle, so the only wrong-path
  // response that can exist is the one arriving during the redirect cycle
  // itself. Suppressing the push on that edge is the complete discard.
  assign push = inflight & ~pc_src;

  assign instr_valid = (count != '0);
  assign pop         = instr_valid & instr_ready;

  always_comb begin
    instr    = NOP;
    instr_pc = '0;
    if (instr_valid) begin
      instr    = q_instr[head];
      instr_pc = q_pc[head];
    end
  end

  // Fetch PC and in-flight tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      inflight <= 1'b0;
    end else begin
      if (pc_src) begin
        fetch_pc <= target_aligned;
      end else if (imem_req) begin
        fetch_pc <= fetch_pc + WIDTH'(4);   // wraps modulo 2^WIDTH
      end
      inflight <= imem_req;
      if (imem_req) begin
        req_pc <= fetch_pc;
      end
    end
  end

  // Queue pointers and occupancy. A redirect empties the queue; a pop in the
  // same edge is simply absorbed by the flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (pc_src) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + AW'(1);
      end
      if (pop) begin
        head <= head + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (push && rst) begin
      q_instr[tail] <= imem_rdata;
      q_pc[tail]    <= req_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_queue
//
// Bench for instr_fetch_queue. A synchronous memory model answers every
// request with word = addr|1. The reference model is the architectural
// instruction stream: after reset or a redirect the consumer must see
// consecutive word addresses starting at the new PC, each carrying addr|1.
// A second instance with RESET_PC=0xFFFFFFF8 checks the start-up PC and wrap.
// -----------------------------------------------------------------------------
module tb_instr_fetch_queue;

  localparam int W = 32;
  localparam logic [W-1:0] NOP  = 32'h0000_0013;
  localparam logic [W-1:0] RPC  = 32'h0000_0000;
  localparam logic [W-1:0] RPCW = 32'hFFFF_FFF8;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b0;
  logic         imem_req;
  logic [W-1:0] imem_addr;
  logic [W-1:0] imem_rdata = 32'hDEAD_BEEF;
  logic [W-1:0] instr;
  logic [W-1:0] instr_pc;
  logic         instr_valid;
  logic         instr_ready = 1'b0;
  logic         pc_src = 1'b0;
  logic [W-1:0] pc_target = '0;

  logic         rst_w = 1'b0;
  logic         w_req;
  logic [W-1:0] w_addr;
  logic [W-1:0] w_rdata = 32'hDEAD_BEEF;
  logic [W-1:0] w_instr;
  logic [W-1:0] w_pc;
  logic         w_valid;

  instr_fetch_queue #(.WIDTH(W), .DEPTH(4), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc_src(pc_src), .pc_target(pc_target)
  );

  instr_fetch_queue #(.WIDTH(W), .DEPTH(4), .RESET_PC(RPCW)) dut_w (
    .clk(clk), .rst(rst_w), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rdata(w_rdata), .instr(w_instr), .instr_pc(w_pc),
    .instr_valid(w_valid), .instr_ready(1'b1),
    .pc_src(1'b0), .pc_target(32'h0)
  );

  // ---------------------------------------------------------------- bookkeeping
  int checks = 0;
  int errors = 0;
  int deliveries = 0;
  int w_count = 0;

  task automatic check_eq(input string name, input logic [W-1:0] act,
                          input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- memory models
  logic         m_req, wm_req;
  logic [W-1:0] m_addr, wm_addr;

  always begin
    @(negedge clk);
    m_req  = imem_req;
    m_addr = imem_addr;
    @(posedge clk);
    #1;
    imem_rdata = m_req ? (m_addr | 32'h1) : 32'hDEAD_BEEF;
  end

  always begin
    @(negedge clk);
    wm_req  = w_req;
    wm_addr = w_addr;
    @(posedge clk);
    #1;
    w_rdata = wm_req ? (wm_addr | 32'h1) : 32'hDEAD_BEEF;
  end

  // ---------------------------------------------------------------- reference model
  logic [W-1:0] exp_q[$];        // PCs the consumer must see next, in order
  logic [W-1:0] exp_tail;        // next PC to append to exp_q
  logic [W-1:0] exp_req_addr;    // next address the fetcher must request
  logic         pend_valid = 1'b0;
  logic [W-1:0] pend_target = '0;
  logic [W-1:0] exp_w = RPCW;

  task automatic fill_expected();
    while (exp_q.size() < 24) begin
      exp_q.push_back(exp_tail);
      exp_tail = exp_tail + 32'd4;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_tail     = RPC;
    exp_req_addr = RPC;
    pend_valid   = 1'b0;
    fill_expected();
  endtask

  // ---------------------------------------------------------------- driver
  // One call = one clock cycle of stimulus. A redirect issued in the previous
  // cycle restarts the expected stream here, after the monitor has already
  // checked any transfer that happened on the redirect edge.
  task automatic step(input logic rdy, input logic src, input logic [W-1:0] tgt);
    @(posedge clk);
    #1;
    if (pend_valid) begin
      exp_q.delete();
      exp_tail   = pend_target;
      pend_valid = 1'b0;
    end
    fill_expected();
    instr_ready = rdy;
    pc_src      = src;
    pc_target   = tgt;
    if (src) begin
      pend_valid  = 1'b1;
      pend_target = tgt & ~32'h3;
    end
  endtask

  task automatic do_reset(input logic rdy);
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    instr_ready = rdy;
    pc_src      = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  // ---------------------------------------------------------------- monitor
  logic [W-1:0] exp_pc;
  logic [1:0]   addr_lo;

  always @(negedge clk) begin
    if (rst) begin
      addr_lo = imem_addr[1:0];
      check_eq("addr_align", {30'd0, addr_lo}, 32'd0);
      if (!instr_valid) begin
        check_eq("idle_instr", instr, NOP);
        check_eq("idle_pc", instr_pc, 32'd0);
      end
      if (pc_src) begin
        check_eq("no_req_on_redirect", {31'd0, imem_req}, 32'd0);
      end
      if (imem_req) begin
        check_eq("req_addr", imem_addr, exp_req_addr);
        exp_req_addr = exp_req_addr + 32'd4;
      end
      if (pc_src) begin
        exp_req_addr = pc_target & ~32'h3;
      end
      if (instr_valid && instr_ready) begin
        check_eq("expected_available", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          exp_pc = exp_q.pop_front();
          check_eq("deliver_pc", instr_pc, exp_pc);
          check_eq("deliver_instr", instr, exp_pc | 32'h1);
          deliveries++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_w && w_valid) begin
      check_eq("wrap_pc", w_pc, exp_w);
      check_eq("wrap_instr", w_instr, exp_w | 32'h1);
      exp_w = exp_w + 32'd4;
      w_count++;
    end
  end

  // ---------------------------------------------------------------- stimulus
  int n_req;
  logic [W-1:0] tgt;

  initial begin
    model_reset();

    // Reset state
    @(negedge clk);
    check_eq("rst_req", {31'd0, imem_req}, 32'd0);
    check_eq("rst_addr", imem_addr, RPC);
    check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("rst_instr", instr, NOP);
    check_eq("rst_pc", instr_pc, 32'd0);

    // Start-up latency and streaming throughput
    instr_ready = 1'b1;
    @(posedge clk);
    #2;
    rst   = 1'b1;
    rst_w = 1'b1;
    @(negedge clk);
    check_eq("first_req", {31'd0, imem_req}, 32'd1);
    check_eq("lat_valid_t0", {31'd0, instr_valid}, 32'd0);
    step(1'b1, 1'b0, '0);
    @(negedge clk);
    check_eq("lat_valid_t1", {31'd0, instr_valid}, 32'd0);
    step(1'b1, 1'b0, '0);
    @(negedge clk);
    check_eq("lat_valid_t2", {31'd0, instr_valid}, 32'd1);
    check_eq("first_pc", instr_pc, 32'd0);
    repeat (8) begin
      step(1'b1, 1'b0, '0);
      @(negedge clk);
      check_eq("throughput", {31'd0, instr_valid}, 32'd1);
    end

    // Stalled consumer: exactly DEPTH requests, then a gapless drain
    do_reset(1'b0);
    n_req = 0;
    repeat (10) begin
      @(negedge clk);
      if (imem_req) n_req++;
      if (instr_valid) check_eq("stall_pc", instr_pc, 32'd0);
      step(1'b0, 1'b0, '0);
    end
    check_eq("stall_req_count", n_req, 32'd4);
    step(1'b1, 1'b0, '0);
    repeat (8) begin
      @(negedge clk);
      check_eq("drain_no_gap", {31'd0, instr_valid}, 32'd1);
      step(1'b1, 1'b0, '0);
    end

    // Redirect with queue 4,8,C and 0x10 in flight
    do_reset(1'b0);
    repeat (6) step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h40);
    @(negedge clk);
    check_eq("redir_head_pc", instr_pc, 32'h4);
    step(1'b0, 1'b0, '0);
    @(negedge clk);
    check_eq("flush_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("flush_instr", instr, NOP);
    check_eq("redir_addr", imem_addr, 32'h40);
    check_eq("redir_req", {31'd0, imem_req}, 32'd1);
    repeat (6) step(1'b1, 1'b0, '0);

    // Unaligned target, then back-to-back redirects
    step(1'b1, 1'b1, 32'h43);
    step(1'b1, 1'b0, '0);
    @(negedge clk);
    check_eq("unaligned_target", imem_addr, 32'h40);
    step(1'b1, 1'b1, 32'h80);
    step(1'b1, 1'b1, 32'h100);
    repeat (8) step(1'b1, 1'b0, '0);

    // Asynchronous reset between clock edges
    repeat (5) step(1'b1, 1'b0, '0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_eq("async_rst_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("async_rst_req", {31'd0, imem_req}, 32'd0);
    check_eq("async_rst_instr", instr, NOP);
    model_reset();
    rst = 1'b1;
    repeat (10) step(1'b1, 1'b0, '0);

    // Randomized traffic
    repeat (2000) begin
      if ($urandom_range(0, 3) == 0)
        tgt = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
      else
        tgt = $urandom;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, tgt);
    end
    step(1'b1, 1'b0, '0);
    repeat (3) @(negedge clk);

    check_eq("progress", {31'd0, deliveries > 500}, 32'd1);
    check_eq("wrap_progress", {31'd0, w_count >= 3}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
